// File: rtl/alu_rs_pkg.sv
// rtl/alu_rs_pkg.sv - shared ALU opcode codes and reservation station defaults
package alu_rs_pkg;

   localparam int DEF_ROB_WIDTH = 4;
   localparam int DEF_RS_SIZE   = 16;
   localparam int DEF_RS_WIDTH  = 4;

   typedef logic [6:0] op_t;

   // Internal op codes shared with the decoder and the ALU
   localparam op_t ADD_type   = 7'd1;
   localparam op_t SUB_type   = 7'd2;
   localparam op_t XOR_type   = 7'd3;
   localparam op_t OR_type    = 7'd4;
   localparam op_t AND_type   = 7'd5;
   localparam op_t SLL_type   = 7'd6;
   localparam op_t SRL_type   = 7'd7;
   localparam op_t SRA_type   = 7'd8;
   localparam op_t SLT_type   = 7'd9;
   localparam op_t SLTU_type  = 7'd10;
   localparam op_t ADDI_type  = 7'd11;
   localparam op_t LUI_type   = 7'd12;
   localparam op_t AUIPC_type = 7'd13;
   localparam op_t BEQ_type   = 7'd14;
   localparam op_t BNE_type   = 7'd15;
   localparam op_t JAL_type   = 7'd16;

endpackage

// File: rtl/alu_rs_if.sv
// rtl/alu_rs_if.sv - registered operand bus from the reservation station to the ALU
interface alu_rs_if
   import alu_rs_pkg::*;
#(
   parameter int ROB_WIDTH = DEF_ROB_WIDTH
);
   logic                 alu_valid_out;
   op_t                  alu_op_out;
   logic [31:0]          alu_pc_out;
   logic [31:0]          alu_rs1_out;
   logic [31:0]          alu_rs2_out;
   logic [31:0]          alu_imm_out;
   logic [ROB_WIDTH-1:0] alu_tag_out;

   modport master (
      output alu_valid_out, alu_op_out, alu_pc_out, alu_rs1_out,
             alu_rs2_out, alu_imm_out, alu_tag_out
   );

   modport slave (
      input alu_valid_out, alu_op_out, alu_pc_out, alu_rs1_out,
            alu_rs2_out, alu_imm_out, alu_tag_out
   );
endinterface

// File: rtl/rs_priority_enc.sv
// rtl/rs_priority_enc.sv - lowest-index set-bit finder with found flag
module rs_priority_enc #(
   parameter int N = 16,
   parameter int W = 4
) (
   input  logic [N-1:0] req,
   output logic [W-1:0] idx,
   output logic         found
);
   // Scan downward so the last hit written is the lowest index
   always_comb begin
      idx   = '0;
      found = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) begin
            idx   = W'(i);
            found = 1'b1;
         end
      end
   end
endmodule

// File: rtl/alu_rs.sv
// rtl/alu_rs.sv - ALU reservation station: CDB wakeup and single lowest-index dispatch
module alu_rs
   import alu_rs_pkg::*;
#(
   parameter int RS_SIZE   = DEF_RS_SIZE,
   parameter int RS_WIDTH  = DEF_RS_WIDTH,
   parameter int ROB_WIDTH = DEF_ROB_WIDTH
) (
   input  logic                 clk_in,
   input  logic                 rst_n,
   input  logic                 rdy_in,
   input  logic                 clear_in,
   input  logic                 issue_valid,
   input  op_t                  issue_op,
   input  logic [31:0]          issue_pc,
   input  logic [31:0]          issue_imm,
   input  logic [31:0]          issue_vj,
   input  logic [ROB_WIDTH-1:0] issue_qj,
   input  logic                 issue_rj,
   input  logic [31:0]          issue_vk,
   input  logic [ROB_WIDTH-1:0] issue_qk,
   input  logic                 issue_rk,
   input  logic [ROB_WIDTH-1:0] issue_tag,
   output logic                 full_out,
   input  logic                 alu_cdb_valid,
   input  logic [ROB_WIDTH-1:0] alu_cdb_tag,
   input  logic [31:0]          alu_cdb_value,
   input  logic                 lsb_cdb_valid,
   input  logic [ROB_WIDTH-1:0] lsb_cdb_tag,
   input  logic [31:0]          lsb_cdb_value,
   alu_rs_if.master             alu
);
   logic [RS_SIZE-1:0]   busy, rj, rk;
   op_t                  op   [RS_SIZE];
   logic [31:0]          pc   [RS_SIZE];
   logic [31:0]          imm  [RS_SIZE];
   logic [31:0]          vj   [RS_SIZE];
   logic [31:0]          vk   [RS_SIZE];
   logic [ROB_WIDTH-1:0] qj   [RS_SIZE];
   logic [ROB_WIDTH-1:0] qk   [RS_SIZE];
   logic [ROB_WIDTH-1:0] tag  [RS_SIZE];

   logic [RS_WIDTH-1:0] free_idx, rdy_idx;
   logic                free_found, rdy_found;
   logic [31:0]         new_vj, new_vk;
   logic                new_rj, new_rk;

   rs_priority_enc #(.N(RS_SIZE), .W(RS_WIDTH)) u_free_enc (
      .req   (~busy),
      .idx   (free_idx),
      .found (free_found)
   );

   rs_priority_enc #(.N(RS_SIZE), .W(RS_WIDTH)) u_rdy_enc (
      .req   (busy & rj & rk),
      .idx   (rdy_idx),
      .found (rdy_found)
   );

   // Reads as full while in reset so the dispatcher never issues into a held block
   assign full_out = ~rst_n | (&busy);

   // Same-cycle bypass of an operand whose producer is broadcasting now
   always_comb begin
      new_vj = issue_vj;
      new_rj = issue_rj;
      new_vk = issue_vk;
      new_rk = issue_rk;
      if (!issue_rj) begin
         if (alu_cdb_valid && alu_cdb_tag == issue_qj) begin
            new_vj = alu_cdb_value;
            new_rj = 1'b1;
         end else if (lsb_cdb_valid && lsb_cdb_tag == issue_qj) begin
            new_vj = lsb_cdb_value;
            new_rj = 1'b1;
         end
      end
      if (!issue_rk) begin
         if (alu_cdb_valid && alu_cdb_tag == issue_qk) begin
            new_vk = alu_cdb_value;
            new_rk = 1'b1;
         end else if (lsb_cdb_valid && lsb_cdb_tag == issue_qk) begin
            new_vk = lsb_cdb_value;
            new_rk = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         busy <= '0;
         rj   <= '0;
         rk   <= '0;
         for (int i = 0; i < RS_SIZE; i++) begin
            op[i]  <= '0;
            pc[i]  <= '0;
            imm[i] <= '0;
            vj[i]  <= '0;
            vk[i]  <= '0;
            qj[i]  <= '0;
            qk[i]  <= '0;
            tag[i] <= '0;
         end
         alu.alu_valid_out <= 1'b0;
         alu.alu_op_out    <= '0;
         alu.alu_pc_out    <= '0;
         alu.alu_rs1_out   <= '0;
         alu.alu_rs2_out   <= '0;
         alu.alu_imm_out   <= '0;
         alu.alu_tag_out   <= '0;
      end else if (rdy_in) begin
         if (clear_in) begin
            busy              <= '0;
            alu.alu_valid_out <= 1'b0;
         end else begin
            for (int i = 0; i < RS_SIZE; i++) begin
               if (busy[i] && !rj[i]) begin
                  if (alu_cdb_valid && alu_cdb_tag == qj[i]) begin
                     vj[i] <= alu_cdb_value;
                     rj[i] <= 1'b1;
                  end else if (lsb_cdb_valid && lsb_cdb_tag == qj[i]) begin
                     vj[i] <= lsb_cdb_value;
                     rj[i] <= 1'b1;
                  end
               end
               if (busy[i] && !rk[i]) begin
                  if (alu_cdb_valid && alu_cdb_tag == qk[i]) begin
                     vk[i] <= alu_cdb_value;
                     rk[i] <= 1'b1;
                  end else if (lsb_cdb_valid && lsb_cdb_tag == qk[i]) begin
                     vk[i] <= lsb_cdb_value;
                     rk[i] <= 1'b1;
                  end
               end
            end

            alu.alu_valid_out <= rdy_found;
            if (rdy_found) begin
               alu.alu_op_out  <= op[rdy_idx];
               alu.alu_pc_out  <= pc[rdy_idx];
               alu.alu_rs1_out <= vj[rdy_idx];
               alu.alu_rs2_out <= vk[rdy_idx];
               alu.alu_imm_out <= imm[rdy_idx];
               alu.alu_tag_out <= tag[rdy_idx];
               busy[rdy_idx]   <= 1'b0;
            end

            // free_idx comes from pre-edge state, so it never aliases the slot dispatched now
            if (issue_valid && free_found) begin
               busy[free_idx] <= 1'b1;
               op[free_idx]   <= issue_op;
               pc[free_idx]   <= issue_pc;
               imm[free_idx]  <= issue_imm;
               vj[free_idx]   <= new_vj;
               rj[free_idx]   <= new_rj;
               qj[free_idx]   <= issue_qj;
               vk[free_idx]   <= new_vk;
               rk[free_idx]   <= new_rk;
               qk[free_idx]   <= issue_qk;
               tag[free_idx]  <= issue_tag;
            end
         end
      end
   end
endmodule

// File: doc/alu_rs.md
Name: alu_rs

Overview:
- Reservation station that feeds the combinational ALU in the out-of-order core. It is the issuing end of the ALU operand interface: pc, rs1, rs2, imm, opcode.
- Accepts decoded ALU-class instructions from the dispatcher and holds them until both operands are valid.
- Operands are captured from the two CDBs (ALU and LSB).
- Each cycle, forwards at most one ready instruction to the ALU through registered outputs, tagged with its ROB index.

Parameters:
- RS_SIZE, 16, number of entries (power of two).
- RS_WIDTH, 4, log2(RS_SIZE).
- ROB_WIDTH, 4, ROB tag width in bits.

Ports:
- clk_in  input  1  system clock.
- rst_n  input  1  reset; one clock, asynchronous, active-low.
- rdy_in  input  1  global ready; when low, all state holds.
- clear_in  input  1  misprediction flush.
- issue_valid  input  1  new instruction this cycle.
- issue_op  input  7  internal op type (the `*_type codes).
- issue_pc  input  32  instruction pc.
- issue_imm  input  32  immediate.
- issue_vj  input  32  rs1 value.
- issue_qj  input  ROB_WIDTH  rs1 producer tag.
- issue_rj  input  1  rs1 value valid.
- issue_vk  input  32  rs2 value.
- issue_qk  input  ROB_WIDTH  rs2 producer tag.
- issue_rk  input  1  rs2 value valid.
- issue_tag  input  ROB_WIDTH  destination ROB index.
- full_out  output  1  no free entry.
- alu_cdb_valid / alu_cdb_tag / alu_cdb_value  input  1 / ROB_WIDTH / 32  ALU result broadcast.
- lsb_cdb_valid / lsb_cdb_tag / lsb_cdb_value  input  1 / ROB_WIDTH / 32  load result broadcast.
- alu_valid_out  output  1  operands below are valid.
- alu_op_out  output  7  to ALU opcode.
- alu_pc_out  output  32  to ALU pc.
- alu_rs1_out  output  32  to ALU rs1.
- alu_rs2_out  output  32  to ALU rs2.
- alu_imm_out  output  32  to ALU imm.
- alu_tag_out  output  ROB_WIDTH  ROB index of the dispatched instruction.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All entry busy bits = 0.
  - alu_valid_out = 0; all alu_*_out = 0.
  - full_out = 1 while held in reset, 0 after release.
- rdy_in low: no state change, outputs hold, CDB inputs ignored.
- Priority each rising edge: reset > clear_in > normal operation.
- clear_in high:
  - All busy bits cleared.
  - alu_valid_out = 0 next cycle.
  - issue_valid and CDB are ignored that cycle.
- Entry fields: busy, op, pc, imm, vj, qj, rj, vk, qk, rk, tag.
- Issue:
  - When issue_valid and a free entry exists, write the lowest-index non-busy entry.
  - Same-cycle bypass: if an operand is not ready and a valid CDB carries the matching tag, store that value with ready=1.
  - If both CDBs match, either may be used; the values are equal by construction.
- Wakeup: every cycle, each busy entry with r=0 and q equal to a valid CDB tag captures the value and sets r=1. Both j and k may wake in the same cycle.
- Dispatch:
  - Select the lowest-index busy entry with rj=rk=1, evaluated on registered state (an entry woken this cycle is eligible next cycle).
  - On the next edge: alu_valid_out=1; alu_rs1_out=vj, alu_rs2_out=vk; op/pc/imm/tag copied; entry freed.
  - If no entry is ready: alu_valid_out=0 and the other outputs hold.
  - Latency: issue with both operands ready → alu_valid_out at cycle +2 (allocate, then select).
- full_out:
  - Combinational; 1 when all RS_SIZE entries are busy in registered state.
  - Does not account for a same-cycle dispatch (conservative).
  - The dispatcher must not assert issue_valid while full_out=1. If it does, the issue is dropped with no corruption.
- Issue and dispatch in the same cycle:
  - Both permitted.
  - The dispatched entry is freed at the same edge and is not reused by that cycle's issue; issue chooses from the pre-edge free set.
- Ordering: no age ordering between ready entries is required; lowest index wins.
- Arithmetic: none inside the block; values pass through unchanged at 32 bits.

Decomposition:
- Shared const package/header holds:
  - the `*_type opcode defines (7-bit), already shared with the ALU and decoder;
  - ROB_WIDTH and RS_SIZE defaults.
- One natural sub-module: rs_priority_enc. It is a parameterised lowest-index-set-bit finder with a found flag. It is instantiated twice: once for the free slot (over ~busy) and once for the ready slot (over busy & rj & rk).

Test Plan:
1. Reset then issue ADD_type, vj=5, vk=7, rj=rk=1, tag=3 → two cycles later alu_valid_out=1, rs1=5, rs2=7, tag=3; the following cycle alu_valid_out=0.
2. Issue SUB_type with qj=2, rj=0, vk=1, rk=1. Three cycles later drive alu_cdb_valid=1, tag=2, value=0x10 → next cycle after wake, outputs rs1=0x10, rs2=1; no dispatch before the wake.
3. Issue with qk=6, rk=0 while lsb_cdb_valid=1, tag=6, value=0xABCD in the same cycle → entry captures via bypass; dispatched with rs2=0xABCD, no stall.
4. Fill all 16 entries with rj=0 → full_out=1; a 17th issue_valid is dropped. Then broadcast the tag for entry 0 → dispatch, full_out=0 the following cycle, and a subsequent issue lands in slot 0.
5. Eight busy entries, two ready; assert clear_in → next cycle alu_valid_out=0 and full_out=0; no dispatch occurs afterwards without new issues.
6. Hold rdy_in=0 for 3 cycles with a ready entry and CDB activity → outputs frozen and CDB ignored; normal dispatch resumes one cycle after rdy_in returns high.
